// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, immediate formats, opcodes, PC/write-back selects.
// ST_TRAP exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , ST_TRAP = 3'd5
`endif
    } state_e;

    localparam logic [2:0] IMM_NONE  = 3'd0;
    localparam logic [2:0] IMM_I     = 3'd1;
    localparam logic [2:0] IMM_SHAMT = 3'd2;
    localparam logic [2:0] IMM_U     = 3'd3;
    localparam logic [2:0] IMM_J     = 3'd4;
    localparam logic [2:0] IMM_B     = 3'd5;
    localparam logic [2:0] IMM_S     = 3'd6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [3:0] {
        CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction/handshake inputs and the control strobes.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_if;
    logic [31:0] inst;
    logic        mem_ready;
    logic        br_cond;
    logic [2:0]  imm_mode;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        alu_src_b;
    logic [2:0]  state_o;
    logic        illegal;

    modport master (
        input  inst, mem_ready, br_cond,
        output imm_mode, ir_we, pc_we, pc_src, mem_req, mem_we,
               reg_we, wb_sel, alu_src_b, state_o, illegal
    );

    modport slave (
        output inst, mem_ready, br_cond,
        input  imm_mode, ir_we, pc_we, pc_src, mem_req, mem_we,
               reg_we, wb_sel, alu_src_b, state_o, illegal
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct3 -> instruction class and immediate format; zero latency.
// Unknown opcodes map to CL_ILLEGAL with IMM_NONE.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output iclass_e    iclass_o,
    output logic [2:0] imm_mode_o
);
    always_comb begin
        iclass_o   = CL_ILLEGAL;
        imm_mode_o = IMM_NONE;
        case (opcode_i)
            OPC_OP:     begin iclass_o = CL_OP;     imm_mode_o = IMM_NONE; end
            OPC_OP_IMM: begin
                iclass_o   = CL_OPIMM;
                // shifts carry a shamt rather than a full I-type immediate
                imm_mode_o = (funct3_i == 3'b001 || funct3_i == 3'b101) ? IMM_SHAMT : IMM_I;
            end
            OPC_LOAD:   begin iclass_o = CL_LOAD;   imm_mode_o = IMM_I; end
            OPC_JALR:   begin iclass_o = CL_JALR;   imm_mode_o = IMM_I; end
            OPC_STORE:  begin iclass_o = CL_STORE;  imm_mode_o = IMM_S; end
            OPC_BRANCH: begin iclass_o = CL_BRANCH; imm_mode_o = IMM_B; end
            OPC_LUI:    begin iclass_o = CL_LUI;    imm_mode_o = IMM_U; end
            OPC_AUIPC:  begin iclass_o = CL_AUIPC;  imm_mode_o = IMM_U; end
            OPC_JAL:    begin iclass_o = CL_JAL;    imm_mode_o = IMM_J; end
            default:    begin iclass_o = CL_ILLEGAL; imm_mode_o = IMM_NONE; end
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction, stalls on mem_ready in FETCH/MEM.
// MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP until reset; otherwise they execute as a NOP.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    state_e     state_q, state_d;
    iclass_e    iclass_q, iclass_d, dec_iclass;
    logic [2:0] imm_mode_q, imm_mode_d, dec_imm;

    logic       ir_we, pc_we, mem_req, mem_we, reg_we, alu_src_b;
    logic [1:0] pc_src, wb_sel;
    logic       unused_inst;

    assign unused_inst = ^{bus.inst[31:15], bus.inst[11:7]};

    mc_decode u_decode (
        .opcode_i   (bus.inst[6:0]),
        .funct3_i   (bus.inst[14:12]),
        .iclass_o   (dec_iclass),
        .imm_mode_o (dec_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            iclass_q   <= CL_ILLEGAL;
            imm_mode_q <= IMM_NONE;
        end else begin
            state_q    <= state_d;
            iclass_q   <= iclass_d;
            imm_mode_q <= imm_mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iclass_d   = iclass_q;
        imm_mode_d = imm_mode_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        alu_src_b  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                iclass_d   = dec_iclass;
                imm_mode_d = dec_imm;
                state_d    = ST_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                if (dec_iclass == CL_ILLEGAL) state_d = ST_TRAP;
`endif
            end
            ST_EXEC: begin
                case (iclass_q)
                    CL_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = bus.br_cond ? PC_IMM : PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                    CL_JAL: begin
                        pc_we = 1'b1; pc_src = PC_IMM; reg_we = 1'b1; wb_sel = WB_PC4;
                        state_d = ST_FETCH;
                    end
                    CL_JALR: begin
                        pc_we = 1'b1; pc_src = PC_ALU; reg_we = 1'b1; wb_sel = WB_PC4;
                        alu_src_b = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CL_LUI: begin
                        reg_we = 1'b1; wb_sel = WB_IMM; pc_we = 1'b1; pc_src = PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                    CL_AUIPC: begin
                        wb_sel  = WB_ALU;
                        state_d = ST_WB;
                    end
                    CL_OP:    state_d = ST_WB;
                    CL_OPIMM: begin alu_src_b = 1'b1; state_d = ST_WB;  end
                    CL_LOAD,
                    CL_STORE: begin alu_src_b = 1'b1; state_d = ST_MEM; end
                    default: begin
                        // illegal opcode without trapping: step over it
                        pc_we   = 1'b1;
                        pc_src  = PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (iclass_q == CL_STORE);
                if (bus.mem_ready) begin
                    if (iclass_q == CL_STORE) begin
                        pc_we   = 1'b1;
                        pc_src  = PC_PLUS4;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (iclass_q == CL_LOAD) ? WB_MEM : WB_ALU;
                pc_we   = 1'b1;
                pc_src  = PC_PLUS4;
                state_d = ST_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
        // reset wins over everything, including a memory access in flight
        if (rst) begin
            ir_we = 1'b0; pc_we = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
            reg_we = 1'b0; alu_src_b = 1'b0; pc_src = PC_PLUS4; wb_sel = WB_ALU;
        end
    end

    assign bus.imm_mode  = imm_mode_q;
    assign bus.ir_we     = ir_we;
    assign bus.pc_we     = pc_we;
    assign bus.pc_src    = pc_src;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.reg_we    = reg_we;
    assign bus.wb_sel    = wb_sel;
    assign bus.alu_src_b = alu_src_b;
    assign bus.state_o   = state_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal   = (state_q == ST_TRAP);
`else
    assign bus.illegal   = 1'b0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected outputs queued at drive time, compared at negedge.
module tb_mc_ctrl;
    typedef struct packed {
        logic [2:0] st;
        logic [2:0] imm;
        logic       ir;
        logic       pw;
        logic [1:0] ps;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] ws;
        logic       ab;
        logic       il;
    } row_t;

    typedef struct packed {
        logic r;
        logic rdy;
        logic bc;
        row_t e;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    row_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic row_t mk(input logic [2:0] st, input logic [2:0] imm, input logic ir,
                                input logic pw, input logic [1:0] ps, input logic mr,
                                input logic mw, input logic rw, input logic [1:0] ws,
                                input logic ab, input logic il);
        row_t t;
        t = '{st: st, imm: imm, ir: ir, pw: pw, ps: ps, mr: mr, mw: mw, rw: rw, ws: ws, ab: ab, il: il};
        return t;
    endfunction

    function automatic stim_t sx(input logic r, input logic rdy, input logic bc, input row_t e);
        stim_t s;
        s = '{r: r, rdy: rdy, bc: bc, e: e};
        return s;
    endfunction

    function automatic row_t sample();
        return mk(bus.state_o, bus.imm_mode, bus.ir_we, bus.pc_we, bus.pc_src, bus.mem_req,
                  bus.mem_we, bus.reg_we, bus.wb_sel, bus.alu_src_b, bus.illegal);
    endfunction

    // drive one cycle of inputs, queue its expectation, land on the sampling edge
    task automatic apply(input stim_t s);
        rst           = s.r;
        bus.mem_ready = s.rdy;
        bus.br_cond   = s.bc;
        exp_q.push_back(s.e);
        @(negedge clk);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        row_t  got, want;
        s.push_back(sx(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(1, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    task automatic test_addi();
        stim_t s[$];
        row_t  got, want;
        bus.inst = 32'h0050_0093;
        s.push_back(sx(0, 1, 0, mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 1, mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        s.push_back(sx(0, 1, 0, mk(4, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL addi row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        row_t  got, want;
        bus.inst = 32'h0000_0463;
        for (int p = 0; p < 2; p++) begin
            logic       bc;
            logic [2:0] prev_imm;
            bc       = (p == 0);
            prev_imm = (p == 0) ? 3'd1 : 3'd5;
            s.push_back(sx(0, 1, 1, mk(0, prev_imm, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
            s.push_back(sx(0, 1, 1, mk(1, prev_imm, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
            s.push_back(sx(0, 1, bc, mk(2, 5, 0, 1, {1'b0, bc}, 0, 0, 0, 0, 0, 0)));
        end
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    task automatic test_store();
        stim_t s[$];
        row_t  got, want;
        bus.inst = 32'h0010_2223;
        s.push_back(sx(0, 0, 0, mk(0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 0, 0, mk(2, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        for (int k = 0; k < 3; k++)
            s.push_back(sx(0, 0, 0, mk(3, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(3, 6, 0, 1, 0, 1, 1, 0, 0, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL store row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    task automatic test_load();
        stim_t s[$];
        row_t  got, want;
        bus.inst = 32'h0040_2103;
        s.push_back(sx(0, 1, 0, mk(0, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        s.push_back(sx(0, 1, 0, mk(3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(4, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    // JAL, LUI, JALR, AUIPC back to back
    task automatic test_back_to_back();
        stim_t       s[$];
        row_t        got, want;
        logic [31:0] ins[$];
        ins = '{32'h0080_006F, 32'h0080_006F, 32'h0080_006F,
                32'h0001_20B7, 32'h0001_20B7, 32'h0001_20B7,
                32'h0000_8067, 32'h0000_8067, 32'h0000_8067,
                32'h0000_0097, 32'h0000_0097, 32'h0000_0097, 32'h0000_0097};
        s.push_back(sx(0, 1, 0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(2, 4, 0, 1, 1, 0, 0, 1, 2, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(0, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(2, 3, 0, 1, 0, 0, 0, 1, 3, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(0, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(2, 1, 0, 1, 2, 0, 0, 1, 2, 1, 0)));
        s.push_back(sx(0, 1, 0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(4, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0)));
        foreach (s[i]) begin
            bus.inst = ins[i];
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    task automatic test_reset_mid_mem();
        stim_t s[$];
        row_t  got, want;
        bus.inst = 32'h0040_2103;
        s.push_back(sx(0, 1, 0, mk(0, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 0, 0, mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        s.push_back(sx(0, 0, 0, mk(3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(1, 1, 0, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid_mem row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    task automatic test_illegal();
        stim_t s[$];
        row_t  got, want;
        bus.inst = 32'hFFFF_FFFF;
        s.push_back(sx(0, 1, 0, mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++)
            s.push_back(sx(0, 1, 1, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        s.push_back(sx(1, 1, 0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        s.push_back(sx(0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
`else
        s.push_back(sx(0, 1, 1, mk(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        s.push_back(sx(0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
`endif
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL illegal row %0d: got %h (state %0d) expected %h (state %0d)", i, got, got.st, want, want.st);
            end
            settle();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.inst      = 32'h0;
        bus.mem_ready = 1'b0;
        bus.br_cond   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_branch();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid_mem();
        test_illegal();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs: inst  in  32  current instruction-register contents; mem_ready  in  1  memory handshake done; br_cond  in  1  branch compare true.
REQ-003 The block SHALL have these outputs: imm_mode  out  3  immediate-generator format select; ir_we  out  1  instruction-register load; pc_we  out  1  PC load.
REQ-004 The block SHALL have these outputs: pc_src  out  2  PC source (0 pc+4, 1 pc+imm, 2 ALU result); mem_req  out  1  memory request; mem_we  out  1  memory write.
REQ-005 The block SHALL have these outputs: reg_we  out  1  register-file write; wb_sel  out  2  write-back source (0 ALU, 1 memory, 2 pc+4, 3 imm); alu_src_b  out  1  ALU operand B (0 rs2, 1 imm).
REQ-006 The block SHALL have these outputs: state_o  out  3  current FSM state; illegal  out  1  illegal opcode flagged.

Function
REQ-007 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; strobes are decoded combinationally from the state, inst and the registered fields.
REQ-008 In FETCH the block SHALL hold mem_req=1 and mem_we=0 until mem_ready=1; in that same cycle it SHALL assert ir_we and move to DECODE.
REQ-009 In DECODE the block SHALL register imm_mode from the opcode and hold it until the next DECODE.
REQ-010 imm_mode encoding: OP-IMM with funct3 001/101 -> 2; other OP-IMM, LOAD and JALR -> 1; STORE -> 6; BRANCH -> 5; LUI and AUIPC -> 3; JAL -> 4; OP -> 0.
REQ-011 An opcode not listed in REQ-010 SHALL be illegal, with handling as set in REQ-021.
REQ-012 EXEC for BRANCH: pc_we=1; pc_src=1 if br_cond=1, else 0; next state FETCH.
REQ-013 EXEC for JAL: pc_we=1, pc_src=1, reg_we=1, wb_sel=2; next state FETCH. JALR is the same but with pc_src=2 and alu_src_b=1.
REQ-014 EXEC for LUI: reg_we=1, wb_sel=3, pc_we=1, pc_src=0; next state FETCH. AUIPC goes to WB with wb_sel=0.
REQ-015 EXEC for OP/OP-IMM SHALL set alu_src_b=1 for OP-IMM and 0 for OP, then go to WB. EXEC for LOAD/STORE SHALL set alu_src_b=1 and go to MEM.
REQ-016 MEM SHALL hold mem_req=1 (mem_we=1 for STORE) until mem_ready=1. On ready, STORE SHALL assert pc_we with pc_src=0 and go to FETCH; LOAD SHALL go to WB.
REQ-017 WB SHALL assert reg_we=1 with wb_sel (1 for LOAD, else 0), plus pc_we=1 and pc_src=0, then go to FETCH.
REQ-018 mem_ready SHALL be ignored outside FETCH and MEM; br_cond SHALL be ignored outside EXEC.
REQ-019 Latency with mem_ready tied to 1: BRANCH/JAL/JALR/LUI 3 cycles; OP/OP-IMM/AUIPC/STORE 4 cycles; LOAD 5 cycles.

Reset
REQ-020 While rst=1 all strobes SHALL be 0; the next state SHALL be FETCH, imm_mode=0 and illegal=0, from any state including mid-MEM.

Configuration
REQ-021 Macro MC_CTRL_ILLEGAL_TRAP_EN: when defined, an illegal opcode in DECODE SHALL go to TRAP, where illegal=1, all strobes are 0 and the block stays until rst; when undefined, an illegal opcode SHALL act as a NOP (EXEC: pc_we=1, pc_src=0 -> FETCH), illegal SHALL stay 0 and there SHALL be no TRAP state.

Structure
REQ-022 The shared package SHALL hold the state encodings, the imm_mode constants (IMM_NONE=0 through IMM_S=6), the opcode constants, and the pc_src/wb_sel encodings; the immediate generator SHALL use the same imm_mode constants.
REQ-023 A sub-module mc_decode (a combinational map from opcode/funct3 to instruction class and imm_mode) is natural; the FSM SHALL stay in mc_ctrl.

Verification
REQ-024 Reset, then inst=0x00500093 (ADDI x1,x0,5) with mem_ready=1: states 0,1,2,4 -> 0; imm_mode=1; reg_we=1, wb_sel=0 in WB.
REQ-025 inst=0x00000463 (BEQ +8) with br_cond=1: imm_mode=5; EXEC gives pc_we=1, pc_src=1. Repeat with br_cond=0: pc_src=0.
REQ-026 inst=0x00102223 (SW) with mem_ready low for 3 MEM cycles: mem_req=mem_we=1 held 4 cycles; imm_mode=6; then pc_we=1 -> FETCH.
REQ-027 inst=0x00402103 (LW): MEM then WB with reg_we=1, wb_sel=1; total 5 cycles.
REQ-028 inst=0xFFFFFFFF: with the macro, state_o=5 and illegal=1 held until rst; without it, the block returns to FETCH with pc_we=1 and illegal=0.
REQ-029 Assert rst during MEM while mem_req=1: strobes are 0 that cycle, and the next cycle has state_o=0 and imm_mode=0.
